// File: rtl/vga_framebuffer_sink.sv
// rtl/vga_framebuffer_sink.sv - 320x240 RRGGBB framebuffer with 640x480@60 pixel-doubled VGA scanout
//
// Purpose:
//   Accepts single-pixel writes from the game datapath into a dual-port
//   framebuffer and continuously scans it out as VGA. Each stored pixel is
//   shown as a 2x2 block. A one-clock frame_start pulse marks the start of
//   vertical blanking so control logic can pace itself to the display.
//
// Ports:
//   clock        in   system clock (50 MHz)
//   reset        in   asynchronous, active-high reset
//   x_position   in   write column
//   y_position   in   write row
//   colour       in   write data {R[1:0],G[1:0],B[1:0]}
//   VGA_enable   in   write strobe, one pixel per clock, never stalled
//   VGA_CLK      out  pixel-rate enable (half the system clock)
//   VGA_HS       out  horizontal sync, active low
//   VGA_VS       out  vertical sync, active low
//   VGA_BLANK_N  out  high while the visible region is being shown
//   VGA_SYNC_N   out  constant 0
//   VGA_R/G/B    out  8-bit colour channels, zero outside the visible region
//   frame_start  out  one-clock pulse as the counters enter the vertical front porch

module vga_framebuffer_sink #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int FB_WIDTH  = 320,
    parameter int FB_HEIGHT = 240
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [8:0] x_position,
    input  logic [7:0] y_position,
    input  logic [5:0] colour,
    input  logic       VGA_enable,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       frame_start
);

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int FB_DEPTH = FB_WIDTH * FB_HEIGHT;
    // 17 bits for the full 320x240 buffer
    localparam int MEM_AW   = $clog2(FB_DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic              pix_en_q;
    logic [9:0]        h_count_q;
    logic [9:0]        h_count_d;
    logic [9:0]        v_count_q;
    logic [9:0]        v_count_d;

    logic              visible;
    logic              hsync_n;
    logic              vsync_n;
    logic              frame_tick;

    logic              wr_en;
    logic [MEM_AW-1:0] wr_addr;
    logic [MEM_AW-1:0] rd_addr;
    logic [5:0]        fb_mem [FB_DEPTH];
    logic [5:0]        rd_data_q;

    // Decode stage aligned with the RAM read
    logic              vis_s1_q;
    logic              hs_s1_q;
    logic              vs_s1_q;

    // Output registers
    logic              hs_q;
    logic              vs_q;
    logic              blank_n_q;
    logic              frame_start_q;
    logic [7:0]        r_q;
    logic [7:0]        g_q;
    logic [7:0]        b_q;

    // ------------------------------------------------------------------
    // Write path: runs every clock regardless of scanout or reset
    // ------------------------------------------------------------------
    assign wr_en   = VGA_enable
                   && ({1'b0, x_position} < 10'(FB_WIDTH))
                   && ({1'b0, y_position} < 9'(FB_HEIGHT));
    // Constant multiply by the row width reduces to shift-and-add,
    // (y<<8)+(y<<6) for the 320-wide buffer.
    assign wr_addr = MEM_AW'(y_position) * MEM_AW'(FB_WIDTH) + MEM_AW'(x_position);

    // ------------------------------------------------------------------
    // Region decode from the live counters
    // ------------------------------------------------------------------
    assign visible = (h_count_q < 10'(H_VISIBLE)) && (v_count_q < 10'(V_VISIBLE));
    assign hsync_n = !((h_count_q >= 10'(HS_START)) && (h_count_q < 10'(HS_END)));
    assign vsync_n = !((v_count_q >= 10'(VS_START)) && (v_count_q < 10'(VS_END)));

    // Outside the visible area the address is parked at 0 so the read
    // never runs past the end of the buffer; the data is discarded anyway.
    assign rd_addr = visible
                   ? (MEM_AW'(v_count_q >> 1) * MEM_AW'(FB_WIDTH) + MEM_AW'(h_count_q >> 1))
                   : '0;

    // Last pixel of the last visible line, on the cycle the counters move.
    assign frame_tick = pix_en_q
                      && (h_count_q == 10'(H_TOTAL - 1))
                      && (v_count_q == 10'(V_VISIBLE - 1));

    // ------------------------------------------------------------------
    // Counter next-state
    // ------------------------------------------------------------------
    always_comb begin
        h_count_d = h_count_q;
        v_count_d = v_count_q;
        if (pix_en_q) begin
            if (h_count_q == 10'(H_TOTAL - 1)) begin
                h_count_d = '0;
                if (v_count_q == 10'(V_TOTAL - 1)) begin
                    v_count_d = '0;
                end else begin
                    v_count_d = v_count_q + 10'd1;
                end
            end else begin
                h_count_d = h_count_q + 10'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Framebuffer RAM. Read-before-write: a same-address collision returns
    // the old pixel, and the new one shows up on the following frame.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (wr_en) begin
            fb_mem[wr_addr] <= colour;
        end
        rd_data_q <= fb_mem[rd_addr];
    end

    // ------------------------------------------------------------------
    // Timing, decode pipeline and output stage
    //
    // Each counter value is held for two clocks. The RAM read and the
    // decode stage capture it on the pix_en=0 cycle, and the output stage
    // loads on the following pix_en=1 cycle, so every output lags the
    // counters by exactly one pixel.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pix_en_q      <= 1'b0;
            h_count_q     <= '0;
            v_count_q     <= '0;
            vis_s1_q      <= 1'b0;
            hs_s1_q       <= 1'b1;
            vs_s1_q       <= 1'b1;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            blank_n_q     <= 1'b0;
            frame_start_q <= 1'b0;
            r_q           <= '0;
            g_q           <= '0;
            b_q           <= '0;
        end else begin
            pix_en_q      <= ~pix_en_q;
            h_count_q     <= h_count_d;
            v_count_q     <= v_count_d;
            vis_s1_q      <= visible;
            hs_s1_q       <= hsync_n;
            vs_s1_q       <= vsync_n;
            frame_start_q <= frame_tick;
            if (pix_en_q) begin
                hs_q      <= hs_s1_q;
                vs_q      <= vs_s1_q;
                blank_n_q <= vis_s1_q;
                // 2-bit channel replicated to fill 8 bits: 2'b10 -> 8'hAA
                r_q       <= vis_s1_q ? {4{rd_data_q[5:4]}} : 8'h00;
                g_q       <= vis_s1_q ? {4{rd_data_q[3:2]}} : 8'h00;
                b_q       <= vis_s1_q ? {4{rd_data_q[1:0]}} : 8'h00;
            end
        end
    end

    assign VGA_CLK     = pix_en_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = blank_n_q;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_R       = r_q;
    assign VGA_G       = g_q;
    assign VGA_B       = b_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_framebuffer_sink.sv
// tb/tb_vga_framebuffer_sink.sv - self-checking bench for vga_framebuffer_sink
module tb_vga_framebuffer_sink;

    // Reduced raster so whole frames fit in a short run
    localparam int HV  = 32;
    localparam int HF  = 4;
    localparam int HSW = 8;
    localparam int HB  = 4;
    localparam int VV  = 24;
    localparam int VF  = 2;
    localparam int VSW = 2;
    localparam int VB  = 4;
    localparam int W   = 16;
    localparam int H   = 12;
    localparam int HT    = HV + HF + HSW + HB;
    localparam int VT    = VV + VF + VSW + VB;
    localparam int FRAME = HT * VT;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [8:0] x_position = '0;
    logic [7:0] y_position = '0;
    logic [5:0] colour = '0;
    logic       VGA_enable = 1'b0;
    logic       VGA_CLK;
    logic       VGA_HS;
    logic       VGA_VS;
    logic       VGA_BLANK_N;
    logic       VGA_SYNC_N;
    logic [7:0] VGA_R;
    logic [7:0] VGA_G;
    logic [7:0] VGA_B;
    logic       frame_start;

    always #5 clock = ~clock;

    vga_framebuffer_sink #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
        .FB_WIDTH(W), .FB_HEIGHT(H)
    ) dut (
        .clock(clock),
        .reset(reset),
        .x_position(x_position),
        .y_position(y_position),
        .colour(colour),
        .VGA_enable(VGA_enable),
        .VGA_CLK(VGA_CLK),
        .VGA_HS(VGA_HS),
        .VGA_VS(VGA_VS),
        .VGA_BLANK_N(VGA_BLANK_N),
        .VGA_SYNC_N(VGA_SYNC_N),
        .VGA_R(VGA_R),
        .VGA_G(VGA_G),
        .VGA_B(VGA_B),
        .frame_start(frame_start)
    );

    int total = 0;
    int bad   = 0;
    int n     = 0;          // clock edges since reset release

    logic [5:0] mfb [W*H];  // reference picture
    logic [5:0] rd_seen   = '0;
    logic [5:0] on_screen = '0;

    bit measure = 0;
    int hs_low_cnt = 0;
    int vs_low_cnt = 0;
    int blank_cnt  = 0;
    int fs_cnt     = 0;

    function automatic logic [7:0] exp8(input logic [1:0] c);
        return {c, c, c, c};
    endfunction

    // clock edge number after which pixel (f,h,v) is on the outputs
    function automatic int pix_n(input int f, input int h, input int v);
        return 2 * (f * FRAME + v * HT + h) + 2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h n=%0d", tag, obs, expv, n);
        end
    endtask

    task automatic check_outputs();
        logic       ehs, evs, evis, efs;
        logic [7:0] er, eg, eb;
        int k, p, h, v;
        if (reset || n < 2) begin
            ehs = 1'b1; evs = 1'b1; evis = 1'b0; efs = 1'b0;
            er = '0; eg = '0; eb = '0;
        end else begin
            k = (n - 2) / 2;
            p = k % FRAME;
            h = p % HT;
            v = p / HT;
            evis = (h < HV) && (v < VV);
            ehs  = !((h >= HV + HF) && (h < HV + HF + HSW));
            evs  = !((v >= VV + VF) && (v < VV + VF + VSW));
            efs  = (n % 2 == 0) && (p == VV * HT - 1);
            er   = evis ? exp8(on_screen[5:4]) : 8'h00;
            eg   = evis ? exp8(on_screen[3:2]) : 8'h00;
            eb   = evis ? exp8(on_screen[1:0]) : 8'h00;
        end
        chk("vga_clk", 32'(VGA_CLK), 32'((!reset) && (n % 2 == 1)));
        chk("hs", 32'(VGA_HS), 32'(ehs));
        chk("vs", 32'(VGA_VS), 32'(evs));
        chk("blank_n", 32'(VGA_BLANK_N), 32'(evis));
        chk("sync_n", 32'(VGA_SYNC_N), 32'(1'b0));
        chk("r", 32'(VGA_R), 32'(er));
        chk("g", 32'(VGA_G), 32'(eg));
        chk("b", 32'(VGA_B), 32'(eb));
        chk("frame_start", 32'(frame_start), 32'(efs));
        if (measure) begin
            if (!VGA_HS) hs_low_cnt++;
            if (!VGA_VS) vs_low_cnt++;
            if (VGA_BLANK_N) blank_cnt++;
            if (frame_start) fs_cnt++;
        end
    endtask

    task automatic tick();
        int k, p, h, v;
        @(posedge clock);
        if (reset) begin
            n = 0;
        end else begin
            n++;
            if (n % 2 == 1) begin
                // pixel being fetched this edge; fetched before any write lands
                k = (n - 1) / 2;
                p = k % FRAME;
                h = p % HT;
                v = p / HT;
                rd_seen = ((h < HV) && (v < VV)) ? mfb[(v / 2) * W + h / 2] : 6'd0;
            end else if (n >= 2) begin
                on_screen = rd_seen;
            end
        end
        if (VGA_enable && int'(x_position) < W && int'(y_position) < H)
            mfb[int'(y_position) * W + int'(x_position)] = colour;
        #1;
        check_outputs();
    endtask

    task automatic write_px(input int x, input int y, input logic [5:0] c);
        x_position = 9'(x);
        y_position = 8'(y);
        colour     = c;
        VGA_enable = 1'b1;
        tick();
        VGA_enable = 1'b0;
    endtask

    task automatic run_to(input int target);
        for (int i = 0; i < 8 * FRAME && n < target; i++) tick();
        chk("reach", 32'(n), 32'(target));
    endtask

    logic [5:0] old00, old10, old_5_10, old_0_11, old_3_2, new_3_2;
    int cnt;
    int fcur;

    initial begin
        // reset asserted asynchronously, before any clock edge
        #1 reset = 1'b1;
        #1 check_outputs();

        // fill the whole buffer while held in reset (writes are not gated)
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                write_px(x, y, 6'($urandom));
        old00    = mfb[0];
        old10    = mfb[1];
        old_5_10 = mfb[10 * W + 5];
        old_0_11 = mfb[11 * W];
        old_3_2  = mfb[2 * W + 3];
        new_3_2  = ~old_3_2;

        reset = 1'b0;
        // edge 1 fetches pixel (0,0): same-cycle write must show old data now
        write_px(0, 0, 6'b110000);
        tick();
        chk("collide00_r", 32'(VGA_R), 32'(exp8(old00[5:4])));
        chk("collide00_b", 32'(VGA_B), 32'(exp8(old00[1:0])));

        write_px(W - 1, H - 1, 6'b000011);
        write_px(W, 10, 6'b111111);
        write_px(5, H, 6'b111111);

        for (int i = 0; i < 40; i++) begin
            x_position = 9'($urandom_range(0, W + 2));
            y_position = 8'($urandom_range(6, 8));
            colour     = 6'($urandom);
            VGA_enable = 1'($urandom_range(0, 1));
            tick();
        end
        VGA_enable = 1'b0;

        // back-to-back row writes, alternating colours
        for (int x = 0; x < W; x++) begin
            x_position = 9'(x);
            y_position = 8'd5;
            colour     = (x % 2 == 0) ? 6'b010101 : 6'b101010;
            VGA_enable = 1'b1;
            tick();
        end
        VGA_enable = 1'b0;

        // frame 1: written pixels now visible
        run_to(pix_n(1, 0, 0));
        chk("p00_r", 32'(VGA_R), 32'(8'hFF));
        chk("p00_g", 32'(VGA_G), 32'(8'h00));
        chk("p00_b", 32'(VGA_B), 32'(8'h00));
        run_to(pix_n(1, 1, 0));
        chk("p10_r", 32'(VGA_R), 32'(8'hFF));
        run_to(pix_n(1, 2, 0));
        chk("p20_r", 32'(VGA_R), 32'(exp8(old10[5:4])));
        chk("p20_g", 32'(VGA_G), 32'(exp8(old10[3:2])));
        chk("p20_b", 32'(VGA_B), 32'(exp8(old10[1:0])));
        run_to(pix_n(1, 0, 1));
        chk("p01_r", 32'(VGA_R), 32'(8'hFF));
        run_to(pix_n(1, 1, 1));
        chk("p11_r", 32'(VGA_R), 32'(8'hFF));
        chk("p11_b", 32'(VGA_B), 32'(8'h00));

        // collision on fb(3,2) exactly when pixel (6,4) is fetched
        run_to(pix_n(1, 6, 4) - 2);
        x_position = 9'd3;
        y_position = 8'd2;
        colour     = new_3_2;
        VGA_enable = 1'b1;
        tick();
        VGA_enable = 1'b0;
        tick();
        chk("collide_old_g", 32'(VGA_G), 32'(exp8(old_3_2[3:2])));
        chk("collide_old_b", 32'(VGA_B), 32'(exp8(old_3_2[1:0])));

        for (int h = 0; h < 2 * W; h++) begin
            run_to(pix_n(1, h, 10));
            chk("row_r", 32'(VGA_R), 32'(((h / 2) % 2 == 0) ? 8'h55 : 8'hAA));
            chk("row_b", 32'(VGA_B), 32'(((h / 2) % 2 == 0) ? 8'h55 : 8'hAA));
        end

        run_to(pix_n(1, 10, 20));
        chk("oob_x_g", 32'(VGA_G), 32'(exp8(old_5_10[3:2])));
        run_to(pix_n(1, 0, 22));
        chk("oob_wrap_r", 32'(VGA_R), 32'(exp8(old_0_11[5:4])));
        run_to(pix_n(1, 31, 23));
        chk("corner_b", 32'(VGA_B), 32'(8'hFF));
        chk("corner_r", 32'(VGA_R), 32'(8'h00));
        run_to(pix_n(1, HV + HF + 2, 23));
        chk("blank_r", 32'(VGA_R), 32'(8'h00));
        chk("blank_bn", 32'(VGA_BLANK_N), 32'(1'b0));
        chk("blank_hs", 32'(VGA_HS), 32'(1'b0));

        // frame 2: collided write now visible
        run_to(pix_n(2, 6, 4));
        chk("collide_new_g", 32'(VGA_G), 32'(exp8(new_3_2[3:2])));
        chk("collide_new_b", 32'(VGA_B), 32'(exp8(new_3_2[1:0])));

        measure = 1;
        repeat (2 * FRAME) tick();
        measure = 0;
        chk("hs_low_clocks", 32'(hs_low_cnt), 32'(VT * 2 * HSW));
        chk("vs_low_clocks", 32'(vs_low_cnt), 32'(VSW * HT * 2));
        chk("blank_high_clocks", 32'(blank_cnt), 32'(VV * HV * 2));
        chk("frame_pulses", 32'(fs_cnt), 32'(1));

        // reset in the middle of a line
        fcur = ((n - 2) / 2) / FRAME + 1;
        run_to(pix_n(fcur, HT / 2, 3));
        #2 reset = 1'b1;
        #1;
        chk("rst_clk", 32'(VGA_CLK), 32'(1'b0));
        chk("rst_hs", 32'(VGA_HS), 32'(1'b1));
        chk("rst_vs", 32'(VGA_VS), 32'(1'b1));
        chk("rst_bn", 32'(VGA_BLANK_N), 32'(1'b0));
        chk("rst_r", 32'(VGA_R), 32'(8'h00));
        chk("rst_g", 32'(VGA_G), 32'(8'h00));
        chk("rst_b", 32'(VGA_B), 32'(8'h00));
        chk("rst_fs", 32'(frame_start), 32'(1'b0));
        repeat (3) tick();
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 2 * HT + 10; i++) begin
            tick();
            cnt++;
            if (!VGA_HS) break;
        end
        chk("hs_first_fall", 32'(cnt), 32'(2 * (HV + HF) + 2));

        run_to(pix_n(0, HT - 1, VV - 1));
        chk("first_fs", 32'(frame_start), 32'(1'b1));
        tick();
        chk("first_fs_end", 32'(frame_start), 32'(1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
